// File: rtl/hash_table_pkg.sv
// Shared types and helpers for the hash table request arbiter.
//   op_e       : client / table operation codes
//   ht_flags_t : table status flags, MSB first
//   onehot()   : index to one-hot vector (up to ONEHOT_W clients)
package hash_table_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  typedef struct packed {
    logic key_already_present;
    logic no_element_found;
    logic no_write_space;
    logic no_deletion_target;
  } ht_flags_t;

  localparam int unsigned ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
    logic [ONEHOT_W-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/hash_table_request_arbiter_tag_fifo.sv
// In-order tag FIFO holding the client index of every issued-but-unanswered op.
//   clk/reset : clock, async active-high reset
//   push/din  : enqueue a tag (ignored when full unless popping the same cycle)
//   pop/dout  : dequeue head; dout always shows the current head
//   empty/full/count : occupancy status
module hash_table_request_arbiter_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hash_table_request_arbiter.sv
// Shares one hash_table between NUM_REQUESTERS clients.
//   req_*  : per-client valid/ready request ports (packed key/data/op)
//   rsp_*  : one-hot response strobe with shared registered data/flags bus
//   ht_*   : issue port to the table and its in-order response port
//   busy_o : ops outstanding or issue register occupied
//   err_orphan_o : sticky, a table response arrived with no tag pending
module hash_table_request_arbiter
  import hash_table_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 4,
  parameter int KEY_WIDTH       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid_i,
  output logic [NUM_REQUESTERS-1:0]            req_ready_o,
  input  logic [NUM_REQUESTERS*KEY_WIDTH-1:0]  req_key_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQUESTERS*2-1:0]          req_op_i,
  output logic [NUM_REQUESTERS-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                rsp_data_o,
  output logic [3:0]                           rsp_flags_o,
  output logic                                 ht_valid_o,
  input  logic                                 ht_ready_i,
  output logic [KEY_WIDTH-1:0]                 ht_key_o,
  output logic [DATA_WIDTH-1:0]                ht_data_o,
  output logic [1:0]                           ht_op_o,
  input  logic                                 ht_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                ht_rsp_data_i,
  input  logic [3:0]                           ht_rsp_flags_i,
  output logic                                 busy_o,
  output logic                                 err_orphan_o
);

  localparam int TAG_W = $clog2(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [KEY_WIDTH-1:0]      key_arr  [NUM_REQUESTERS];
  logic [DATA_WIDTH-1:0]     data_arr [NUM_REQUESTERS];
  op_e                       op_arr   [NUM_REQUESTERS];

  logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [KEY_WIDTH-1:0]      issue_key_q, issue_key_d;
  logic [DATA_WIDTH-1:0]     issue_data_q, issue_data_d;
  op_e                       issue_op_q, issue_op_d;
  logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  ht_flags_t                 rsp_flags_q, rsp_flags_d;
  logic                      err_q, err_d;

  logic [TAG_W-1:0]          winner;
  logic [TAG_W-1:0]          cand;
  logic                      found;
  logic                      handshake;
  logic                      load;
  logic                      pop;
  logic [TAG_W-1:0]          fifo_head;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [CNT_W-1:0]          fifo_count;

  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      key_arr[i]  = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
      data_arr[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      op_arr[i]   = op_e'(req_op_i[i*2 +: 2]);
    end
  end

  // Round-robin search starts one past the last winner and wraps.
  always_comb begin
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQUESTERS);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Full FIFO means the registered outstanding count has reached the limit;
  // a pop in the same cycle does not reopen the grant.
  assign handshake   = found & ~fifo_full & (~issue_valid_q | ht_ready_i);
  assign load        = handshake & (op_arr[winner] != OP_NOP);
  assign pop         = ht_rsp_valid_i & ~fifo_empty;
  assign req_ready_o = (handshake && !reset) ?
                       NUM_REQUESTERS'(onehot(5'(winner))) : '0;

  always_comb begin
    rr_ptr_d      = handshake ? winner : rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_key_d   = issue_key_q;
    issue_data_d  = issue_data_q;
    issue_op_d    = issue_op_q;
    if (issue_valid_q && ht_ready_i) begin
      issue_valid_d = 1'b0;
      issue_key_d   = '0;
      issue_data_d  = '0;
      issue_op_d    = OP_NOP;
    end
    if (load) begin
      issue_valid_d = 1'b1;
      issue_key_d   = key_arr[winner];
      issue_data_d  = data_arr[winner];
      issue_op_d    = op_arr[winner];
    end
    rsp_valid_d = pop ? NUM_REQUESTERS'(onehot(5'(fifo_head))) : '0;
    rsp_data_d  = pop ? ht_rsp_data_i : rsp_data_q;
    rsp_flags_d = pop ? ht_flags_t'(ht_rsp_flags_i) : rsp_flags_q;
    err_d       = err_q | (ht_rsp_valid_i & fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q      <= TAG_W'(NUM_REQUESTERS - 1);
      issue_valid_q <= 1'b0;
      issue_key_q   <= '0;
      issue_data_q  <= '0;
      issue_op_q    <= OP_NOP;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_key_q   <= issue_key_d;
      issue_data_q  <= issue_data_d;
      issue_op_q    <= issue_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_flags_q   <= rsp_flags_d;
      err_q         <= err_d;
    end
  end

  hash_table_request_arbiter_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (load),
    .pop   (pop),
    .din   (winner),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign ht_valid_o   = issue_valid_q;
  assign ht_key_o     = issue_key_q;
  assign ht_data_o    = issue_data_q;
  assign ht_op_o      = issue_op_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign busy_o       = (fifo_count != '0) | issue_valid_q;
  assign err_orphan_o = err_q;

endmodule

// File: tb/tb_hash_table_request_arbiter.sv
// Self-checking bench for hash_table_request_arbiter. The bench plays the
// clients and the hash table; a queue-based model predicts every output.
module tb_hash_table_request_arbiter;

  localparam int NR = 4;
  localparam int KW = 2;
  localparam int DW = 32;
  localparam int MO = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req_valid_i = '0;
  logic [NR-1:0]    req_ready_o;
  logic [NR*KW-1:0] req_key_i = '0;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR*2-1:0]  req_op_i = '0;
  logic [NR-1:0]    rsp_valid_o;
  logic [DW-1:0]    rsp_data_o;
  logic [3:0]       rsp_flags_o;
  logic             ht_valid_o;
  logic             ht_ready_i = 1'b0;
  logic [KW-1:0]    ht_key_o;
  logic [DW-1:0]    ht_data_o;
  logic [1:0]       ht_op_o;
  logic             ht_rsp_valid_i = 1'b0;
  logic [DW-1:0]    ht_rsp_data_i = '0;
  logic [3:0]       ht_rsp_flags_i = '0;
  logic             busy_o;
  logic             err_orphan_o;

  always #5 clk = ~clk;

  hash_table_request_arbiter #(
    .NUM_REQUESTERS (NR),
    .KEY_WIDTH      (KW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_key_i     (req_key_i),
    .req_data_i    (req_data_i),
    .req_op_i      (req_op_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_flags_o   (rsp_flags_o),
    .ht_valid_o    (ht_valid_o),
    .ht_ready_i    (ht_ready_i),
    .ht_key_o      (ht_key_o),
    .ht_data_o     (ht_data_o),
    .ht_op_o       (ht_op_o),
    .ht_rsp_valid_i(ht_rsp_valid_i),
    .ht_rsp_data_i (ht_rsp_data_i),
    .ht_rsp_flags_i(ht_rsp_flags_i),
    .busy_o        (busy_o),
    .err_orphan_o  (err_orphan_o)
  );

  int checks = 0;
  int failures = 0;

  // Model state: last winner, tags of outstanding ops, contents of the issue slot.
  int            m_rr;
  int            q_out[$];
  logic          m_iv;
  logic [KW-1:0] m_key;
  logic [DW-1:0] m_data;
  logic [1:0]    m_op;
  logic [NR-1:0] m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  logic [3:0]    m_rsp_flags;
  logic          m_err;
  int            tbl_cnt;       // ops the table has accepted but not answered
  logic [NR-1:0] act_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rr        = NR - 1;
    q_out.delete();
    m_iv        = 1'b0;
    m_key       = '0;
    m_data      = '0;
    m_op        = '0;
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    m_rsp_flags = '0;
    m_err       = 1'b0;
    tbl_cnt     = 0;
  endfunction

  function automatic int pick_winner();
    if (q_out.size() >= MO) return -1;
    if (m_iv && !ht_ready_i) return -1;
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (m_rr + k) % NR;
      if (req_valid_i[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    chk({tag, "_ht_valid"},  64'(ht_valid_o),  64'd0);
    chk({tag, "_ht_key"},    64'(ht_key_o),    64'd0);
    chk({tag, "_ht_data"},   64'(ht_data_o),   64'd0);
    chk({tag, "_ht_op"},     64'(ht_op_o),     64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_rsp_data"},  64'(rsp_data_o),  64'd0);
    chk({tag, "_rsp_flags"}, 64'(rsp_flags_o), 64'd0);
    chk({tag, "_busy"},      64'(busy_o),      64'd0);
    chk({tag, "_err"},       64'(err_orphan_o), 64'd0);
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step();
    int   w;
    logic xfer;
    logic [1:0] op;
    #2;
    w = pick_winner();
    act_ready = req_ready_o;
    chk("req_ready", 64'(req_ready_o), (w >= 0) ? (64'd1 << w) : 64'd0);
    @(posedge clk);
    xfer = m_iv && ht_ready_i;
    m_rsp_valid = '0;
    if (ht_rsp_valid_i) begin
      if (q_out.size() > 0) begin
        m_rsp_valid = NR'(1 << q_out.pop_front());
        m_rsp_data  = ht_rsp_data_i;
        m_rsp_flags = ht_rsp_flags_i;
      end else begin
        m_err = 1'b1;
      end
      if (tbl_cnt > 0) tbl_cnt--;
    end
    if (xfer) begin
      tbl_cnt++;
      m_iv = 1'b0; m_key = '0; m_data = '0; m_op = '0;
    end
    if (w >= 0) begin
      m_rr = w;
      op = req_op_i[w*2 +: 2];
      if (op != 2'b00) begin
        q_out.push_back(w);
        m_iv   = 1'b1;
        m_key  = req_key_i[w*KW +: KW];
        m_data = req_data_i[w*DW +: DW];
        m_op   = op;
      end
    end
    #1;
    chk("ht_valid",  64'(ht_valid_o),   64'(m_iv));
    chk("ht_key",    64'(ht_key_o),     64'(m_key));
    chk("ht_data",   64'(ht_data_o),    64'(m_data));
    chk("ht_op",     64'(ht_op_o),      64'(m_op));
    chk("rsp_valid", 64'(rsp_valid_o),  64'(m_rsp_valid));
    chk("rsp_data",  64'(rsp_data_o),   64'(m_rsp_data));
    chk("rsp_flags", 64'(rsp_flags_o),  64'(m_rsp_flags));
    chk("busy",      64'(busy_o),       64'((q_out.size() != 0) || m_iv));
    chk("err",       64'(err_orphan_o), 64'(m_err));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    model_reset();
    check_all_zero({tag, "_async"});
    @(posedge clk);
    #1;
    check_all_zero({tag, "_edge"});
    reset = 1'b0;
  endtask

  task automatic drive_random(input int p_valid, input int p_ready, input int p_rsp);
    for (int i = 0; i < NR; i++) begin
      req_valid_i[i]          = ($urandom_range(0, 99) < p_valid);
      req_key_i[i*KW +: KW]   = KW'($urandom);
      req_data_i[i*DW +: DW]  = $urandom;
      req_op_i[i*2 +: 2]      = 2'($urandom);
    end
    ht_ready_i     = ($urandom_range(0, 99) < p_ready);
    ht_rsp_valid_i = (tbl_cnt > 0) && ($urandom_range(0, 99) < p_rsp);
    ht_rsp_data_i  = $urandom;
    ht_rsp_flags_i = 4'($urandom);
  endtask

  task automatic all_valid(input logic [1:0] op);
    req_valid_i = '1;
    for (int i = 0; i < NR; i++) begin
      req_op_i[i*2 +: 2]     = op;
      req_key_i[i*KW +: KW]  = KW'(i);
      req_data_i[i*DW +: DW] = 32'hA000_0000 + i;
    end
  endtask

  initial begin
    logic [NR-1:0] grants[$];
    logic [NR-1:0] rsps[$];
    int n_grants;

    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset during traffic, then first grant goes to client 0
    for (int c = 0; c < 20; c++) begin
      drive_random(70, 70, 50);
      step();
    end
    all_valid(2'b01);
    do_reset("t1");
    ht_ready_i = 1'b1;
    ht_rsp_valid_i = 1'b0;
    step();
    chk("t1_first_grant", 64'(act_ready), 64'b0001);

    // 2: single READ from client 2 and its response
    do_reset("t2");
    req_valid_i = 4'b0100;
    req_op_i[2*2 +: 2] = 2'b01;
    req_key_i[2*KW +: KW] = 2'b01;
    ht_ready_i = 1'b1;
    step();
    chk("t2_ht_valid", 64'(ht_valid_o), 64'd1);
    chk("t2_ht_op",    64'(ht_op_o),    64'b01);
    chk("t2_ht_key",   64'(ht_key_o),   64'b01);
    req_valid_i = '0;
    step();
    ht_rsp_valid_i = 1'b1;
    ht_rsp_data_i  = 32'hDEADBEEF;
    ht_rsp_flags_i = 4'b0000;
    step();
    ht_rsp_valid_i = 1'b0;
    chk("t2_rsp_valid", 64'(rsp_valid_o), 64'b0100);
    chk("t2_rsp_data",  64'(rsp_data_o),  64'hDEADBEEF);

    // 3: continuous requests, immediate responses -> rotating grants and responses
    do_reset("t3");
    all_valid(2'b01);
    ht_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ht_rsp_valid_i = (tbl_cnt > 0);
      ht_rsp_data_i  = 32'h5000_0000 + c;
      step();
      grants.push_back(act_ready);
      if (rsp_valid_o != '0) rsps.push_back(rsp_valid_o);
    end
    ht_rsp_valid_i = 1'b0;
    chk("t3_g0", 64'(grants[0]), 64'b0001);
    chk("t3_g1", 64'(grants[1]), 64'b0010);
    chk("t3_g2", 64'(grants[2]), 64'b0100);
    chk("t3_g3", 64'(grants[3]), 64'b1000);
    chk("t3_g4", 64'(grants[4]), 64'b0001);
    chk("t3_nrsp", 64'(rsps.size() >= 4), 64'd1);
    if (rsps.size() >= 4) begin
      chk("t3_r0", 64'(rsps[0]), 64'b0001);
      chk("t3_r1", 64'(rsps[1]), 64'b0010);
      chk("t3_r2", 64'(rsps[2]), 64'b0100);
      chk("t3_r3", 64'(rsps[3]), 64'b1000);
    end

    // 4: outstanding limit with withheld responses
    do_reset("t4");
    all_valid(2'b01);
    ht_ready_i = 1'b1;
    n_grants = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (act_ready != '0) n_grants++;
    end
    chk("t4_grants", 64'(n_grants), 64'd4);
    chk("t4_blocked", 64'(act_ready), 64'd0);
    ht_rsp_valid_i = 1'b1;
    step();
    chk("t4_pop_cycle", 64'(act_ready), 64'd0);
    ht_rsp_valid_i = 1'b0;
    step();
    chk("t4_regrant", 64'(act_ready), 64'b0001);

    // 5: table back-pressure holds the issue register
    do_reset("t5");
    all_valid(2'b10);
    req_valid_i = 4'b0010;
    req_key_i[1*KW +: KW]  = 2'b10;
    req_data_i[1*DW +: DW] = 32'h1234_5678;
    ht_ready_i = 1'b0;
    step();
    req_valid_i = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_no_grant", 64'(act_ready), 64'd0);
      chk("t5_key",  64'(ht_key_o),  64'b10);
      chk("t5_data", 64'(ht_data_o), 64'h1234_5678);
      chk("t5_op",   64'(ht_op_o),   64'b10);
    end
    ht_ready_i = 1'b1;
    step();
    chk("t5_rise_grant", 64'(act_ready), 64'b0100);
    chk("t5_tbl_accepted", 64'(tbl_cnt), 64'd1);

    // 6: orphan response sets a sticky error
    do_reset("t6");
    req_valid_i = '0;
    ht_rsp_valid_i = 1'b1;
    ht_rsp_data_i = 32'hBAD0_BAD0;
    step();
    ht_rsp_valid_i = 1'b0;
    chk("t6_no_rsp", 64'(rsp_valid_o), 64'd0);
    chk("t6_err",    64'(err_orphan_o), 64'd1);
    for (int c = 0; c < 30; c++) begin
      drive_random(80, 70, 60);
      step();
    end
    chk("t6_err_held", 64'(err_orphan_o), 64'd1);
    do_reset("t6_clr");

    // Randomized traffic across several load profiles, with a reset in the middle
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        case (ph)
          0: drive_random(50, 80, 60);
          1: drive_random(90, 40, 30);
          2: drive_random(30, 95, 90);
          default: drive_random(100, 60, 10);
        endcase
        step();
      end
      if (ph == 1) do_reset("mid");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
